// File: rtl/run_result_checker_if.sv
// rtl/run_result_checker_if.sv - debug read ports into the register file and main memory
// master = checker side, slave = register file / memory model side.
interface run_result_checker_if #(
   parameter int WORD_W      = 32,
   parameter int LINE_WORDS  = 4,
   parameter int LINE_ADDR_W = 10
);
   logic [4:0]                   reg_rd_addr;
   logic [WORD_W-1:0]            reg_rd_data;
   logic                         mem_rd_req;
   logic [LINE_ADDR_W-1:0]       mem_rd_line;
   logic                         mem_rd_ack;
   logic [LINE_WORDS*WORD_W-1:0] mem_rd_data;

   modport master (
      output reg_rd_addr,
      input  reg_rd_data,
      output mem_rd_req,
      output mem_rd_line,
      input  mem_rd_ack,
      input  mem_rd_data
   );

   modport slave (
      input  reg_rd_addr,
      output reg_rd_data,
      input  mem_rd_req,
      input  mem_rd_line,
      output mem_rd_ack,
      output mem_rd_data
   );
endinterface

// File: rtl/run_result_checker.sv
// rtl/run_result_checker.sv - end-of-run checker: cycle count to halt/watchdog, then table scan
// Registers are compared combinationally one per cycle; memory words via a held line request.
module run_result_checker #(
   parameter int NUM_REG_CHK = 16,
   parameter int NUM_MEM_CHK = 16,
   parameter int WORD_W      = 32,
   parameter int LINE_WORDS  = 4,
   parameter int LINE_ADDR_W = 10,
   parameter int TIMEOUT     = 500,
   parameter int CNT_W       = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    halt,
   input  logic                    cfg_we,
   input  logic                    cfg_sel,
   input  logic [7:0]              cfg_idx,
   input  logic                    cfg_valid,
   input  logic [15:0]             cfg_addr,
   input  logic [WORD_W-1:0]       cfg_value,
   run_result_checker_if.master    dbg,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    timeout,
   output logic [CNT_W-1:0]        cycle_count,
   output logic [15:0]             pass_count,
   output logic [15:0]             fail_count,
   output logic [8:0]              first_fail_idx,
   output logic [WORD_W-1:0]       first_fail_got
);
   localparam int MAX_CHK    = (NUM_REG_CHK > NUM_MEM_CHK) ? NUM_REG_CHK : NUM_MEM_CHK;
   localparam int IDX_W      = $clog2(MAX_CHK);
   localparam int LINE_SHIFT = $clog2(LINE_WORDS * 4);
   localparam int WSEL_W     = $clog2(LINE_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_REG_CHK, S_MEM_REQ, S_MEM_WAIT, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic              reg_valid [NUM_REG_CHK];
   logic [4:0]        reg_addr  [NUM_REG_CHK];
   logic [WORD_W-1:0] reg_value [NUM_REG_CHK];
   logic              mem_valid [NUM_MEM_CHK];
   logic [15:0]       mem_addr  [NUM_MEM_CHK];
   logic [WORD_W-1:0] mem_value [NUM_MEM_CHK];

   logic [IDX_W-1:0]       idx;
   logic                   idle_or_done;
   logic                   last_reg;
   logic                   last_mem;
   logic                   at_limit;
   logic [WSEL_W-1:0]      word_sel;
   logic [WORD_W-1:0]      mem_word;
   logic [4:0]             reg_rd_addr_c;
   logic                   mem_rd_req_c;
   logic [LINE_ADDR_W-1:0] mem_rd_line_c;
   logic                   cmp_en;
   logic                   cmp_tbl;
   logic [WORD_W-1:0]      cmp_got;
   logic [WORD_W-1:0]      cmp_exp;

   assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
   assign last_reg     = (idx == IDX_W'(NUM_REG_CHK - 1));
   assign last_mem     = (idx == IDX_W'(NUM_MEM_CHK - 1));
   assign at_limit     = (cycle_count == CNT_W'(TIMEOUT - 1));
   assign word_sel     = WSEL_W'(mem_addr[idx] >> 2);

   always_comb begin
      mem_word = '0;
      for (int w = 0; w < LINE_WORDS; w++) begin
         if (word_sel == WSEL_W'(w)) mem_word = dbg.mem_rd_data[w*WORD_W +: WORD_W];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
         S_RUN:          if (halt || at_limit) state_nxt = S_REG_CHK;
         S_REG_CHK:      if (last_reg) state_nxt = S_MEM_REQ;
         S_MEM_REQ: begin
            if (mem_valid[idx]) state_nxt = S_MEM_WAIT;
            else if (last_mem)  state_nxt = S_DONE;
         end
         S_MEM_WAIT:     if (dbg.mem_rd_ack) state_nxt = last_mem ? S_DONE : S_MEM_REQ;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state == S_RUN) || (state == S_REG_CHK) ||
                      (state == S_MEM_REQ) || (state == S_MEM_WAIT);
      done          = (state == S_DONE);
      reg_rd_addr_c = '0;
      mem_rd_req_c  = 1'b0;
      mem_rd_line_c = '0;
      cmp_en        = 1'b0;
      cmp_tbl       = 1'b0;
      cmp_got       = '0;
      cmp_exp       = '0;
      case (state)
         S_REG_CHK: begin
            reg_rd_addr_c = reg_addr[idx];
            cmp_en        = reg_valid[idx];
            cmp_got       = dbg.reg_rd_data;
            cmp_exp       = reg_value[idx];
         end
         S_MEM_WAIT: begin
            mem_rd_req_c  = 1'b1;
            mem_rd_line_c = LINE_ADDR_W'(mem_addr[idx] >> LINE_SHIFT);
            cmp_en        = dbg.mem_rd_ack;
            cmp_tbl       = 1'b1;
            cmp_got       = mem_word;
            cmp_exp       = mem_value[idx];
         end
         default: ;
      endcase
   end

   assign dbg.reg_rd_addr = reg_rd_addr_c;
   assign dbg.mem_rd_req  = mem_rd_req_c;
   assign dbg.mem_rd_line = mem_rd_line_c;
   assign pass = done && (fail_count == 16'd0) && !timeout;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REG_CHK; i++) begin
            reg_valid[i] <= 1'b0;
            reg_addr[i]  <= '0;
            reg_value[i] <= '0;
         end
         for (int i = 0; i < NUM_MEM_CHK; i++) begin
            mem_valid[i] <= 1'b0;
            mem_addr[i]  <= '0;
            mem_value[i] <= '0;
         end
         idx            <= '0;
         cycle_count    <= '0;
         pass_count     <= '0;
         fail_count     <= '0;
         timeout        <= 1'b0;
         first_fail_idx <= 9'h1FF;
         first_fail_got <= '0;
      end else begin
         if (cfg_we && idle_or_done) begin
            if (!cfg_sel && (cfg_idx < 8'(NUM_REG_CHK))) begin
               reg_valid[cfg_idx[IDX_W-1:0]] <= cfg_valid;
               reg_addr[cfg_idx[IDX_W-1:0]]  <= cfg_addr[4:0];
               reg_value[cfg_idx[IDX_W-1:0]] <= cfg_value;
            end
            if (cfg_sel && (cfg_idx < 8'(NUM_MEM_CHK))) begin
               mem_valid[cfg_idx[IDX_W-1:0]] <= cfg_valid;
               mem_addr[cfg_idx[IDX_W-1:0]]  <= cfg_addr;
               mem_value[cfg_idx[IDX_W-1:0]] <= cfg_value;
            end
         end
         if (start && idle_or_done) begin
            idx            <= '0;
            cycle_count    <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            timeout        <= 1'b0;
            first_fail_idx <= 9'h1FF;
            first_fail_got <= '0;
         end
         case (state)
            S_RUN: begin
               if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
               // halt on the limit cycle wins over the watchdog
               if (!halt && at_limit) timeout <= 1'b1;
            end
            S_REG_CHK:  idx <= last_reg ? '0 : idx + 1'b1;
            S_MEM_REQ:  if (!mem_valid[idx]) idx <= idx + 1'b1;
            S_MEM_WAIT: if (dbg.mem_rd_ack) idx <= idx + 1'b1;
            default: ;
         endcase
         if (cmp_en) begin
            if (cmp_got == cmp_exp) begin
               if (pass_count != 16'hFFFF) pass_count <= pass_count + 1'b1;
            end else begin
               if (fail_count != 16'hFFFF) fail_count <= fail_count + 1'b1;
               if (first_fail_idx == 9'h1FF) begin
                  first_fail_idx <= {cmp_tbl, 8'(idx)};
                  first_fail_got <= cmp_got;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_run_result_checker.sv
// tb/tb_run_result_checker.sv - directed bench for run_result_checker
// Register file and memory are small behavioural models; memory ack latency is programmable.
module tb_run_result_checker;
   localparam int WORD_W      = 32;
   localparam int LINE_WORDS  = 4;
   localparam int LINE_ADDR_W = 10;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        halt = 1'b0;
   logic        cfg_we = 1'b0;
   logic        cfg_sel = 1'b0;
   logic [7:0]  cfg_idx = '0;
   logic        cfg_valid = 1'b0;
   logic [15:0] cfg_addr = '0;
   logic [31:0] cfg_value = '0;
   logic        busy, done, pass, timeout;
   logic [63:0] cycle_count;
   logic [15:0] pass_count, fail_count;
   logic [8:0]  first_fail_idx;
   logic [31:0] first_fail_got;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   run_result_checker_if #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .LINE_ADDR_W(LINE_ADDR_W)) dbg ();

   run_result_checker dut (
      .clock(clock), .reset(reset), .start(start), .halt(halt),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
      .cfg_addr(cfg_addr), .cfg_value(cfg_value), .dbg(dbg),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .cycle_count(cycle_count), .pass_count(pass_count), .fail_count(fail_count),
      .first_fail_idx(first_fail_idx), .first_fail_got(first_fail_got)
   );

   logic [31:0]  regs [0:31];
   logic [127:0] mem_line [0:3];
   logic         ack = 1'b0;
   int           lat_cfg = 3;
   int           wait_cnt = 0;
   int           req_cnt = 0;
   int           line0_cnt = 0;
   int           hold_viol = 0;
   logic         prev_req = 1'b0;
   logic         prev_ack = 1'b0;
   logic [9:0]   prev_line = '0;

   assign dbg.reg_rd_data = regs[dbg.reg_rd_addr];
   assign dbg.mem_rd_data = (dbg.mem_rd_line < 10'd4) ? mem_line[dbg.mem_rd_line[1:0]] : '0;
   assign dbg.mem_rd_ack  = ack;

   // request monitor first, then the responder, then remember this cycle's values
   always @(negedge clock) begin
      if (reset) begin
         if (dbg.mem_rd_req && !prev_req) begin
            req_cnt++;
            if (dbg.mem_rd_line == 10'd0) line0_cnt++;
         end
         if (prev_req && !prev_ack && (!dbg.mem_rd_req || dbg.mem_rd_line != prev_line)) hold_viol++;
         if (prev_ack && dbg.mem_rd_req) hold_viol++;
      end
      if (!dbg.mem_rd_req || ack) begin
         ack = 1'b0;
         wait_cnt = 0;
      end else if (wait_cnt >= lat_cfg - 1) begin
         ack = 1'b1;
      end else begin
         wait_cnt++;
      end
      prev_req  = dbg.mem_rd_req;
      prev_ack  = ack;
      prev_line = dbg.mem_rd_line;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic cfg_write(input logic sel, input int idx, input logic valid,
                            input logic [15:0] addr, input logic [31:0] value);
      cfg_we = 1'b1; cfg_sel = sel; cfg_idx = 8'(idx);
      cfg_valid = valid; cfg_addr = addr; cfg_value = value;
      @(negedge clock);
      cfg_we = 1'b0;
   endtask

   // halt_at: edge (after the start edge) at which halt is sampled; 0 = never
   task automatic run_test(input int halt_at, input int start_at, input int cfg_at, output int lat);
      lat = -1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 1; i <= 2000; i++) begin
         halt  = (i == halt_at);
         start = (i == start_at);
         if (i == cfg_at) begin
            cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 8'd8;
            cfg_valid = 1'b1; cfg_addr = 16'd1; cfg_value = 32'd99;
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clock);
         if (done) begin
            lat = i + 1 - halt_at;
            break;
         end
      end
      halt = 1'b0; start = 1'b0; cfg_we = 1'b0;
      check_eq("run_done", done, 1);
   endtask

   int lat;
   int req_base;
   int l0_base;

   initial begin
      for (int r = 0; r < 32; r++) regs[r] = 32'd0;
      regs[1] = 32'd5; regs[2] = 32'd10; regs[3] = 32'd15;
      regs[4] = 32'd9; regs[6] = 32'd7;
      mem_line[0] = {32'd0, 32'd1234, 32'd10, 32'd5};
      mem_line[1] = 128'h0;
      mem_line[2] = 128'h0;
      mem_line[3] = 128'h0;

      @(negedge clock);
      do_reset();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_pass", pass, 0);
      check_eq("rst_timeout", timeout, 0);
      check_eq("rst_cycles", cycle_count, 0);
      check_eq("rst_pass_cnt", pass_count, 0);
      check_eq("rst_fail_cnt", fail_count, 0);
      check_eq("rst_ff_idx", first_fail_idx, 9'h1FF);
      check_eq("rst_ff_got", first_fail_got, 0);
      check_eq("rst_req", dbg.mem_rd_req, 0);

      // empty tables: halt-to-done latency and vacuous pass
      run_test(5, 0, 0, lat);
      check_eq("empty_latency", lat, 33);
      check_eq("empty_pass", pass, 1);
      check_eq("empty_pass_cnt", pass_count, 0);
      check_eq("empty_cycles", cycle_count, 5);

      // memory word select, ack latency 3
      lat_cfg = 3;
      cfg_write(1'b1, 0, 1'b1, 16'd0, 32'd5);
      cfg_write(1'b1, 1, 1'b1, 16'd4, 32'd10);
      cfg_write(1'b1, 2, 1'b1, 16'd8, 32'd1234);
      req_base = req_cnt; l0_base = line0_cnt;
      run_test(10, 0, 0, lat);
      check_eq("mem_pass_cnt", pass_count, 3);
      check_eq("mem_fail_cnt", fail_count, 0);
      check_eq("mem_req_cnt", req_cnt - req_base, 3);
      check_eq("mem_line0_cnt", line0_cnt - l0_base, 3);
      check_eq("mem_req_hold", hold_viol, 0);
      check_eq("mem_pass", pass, 1);

      // register-only pass after a reset wipes the memory table
      do_reset();
      cfg_write(1'b0, 0, 1'b1, 16'd1, 32'd5);
      cfg_write(1'b0, 1, 1'b1, 16'd2, 32'd10);
      cfg_write(1'b0, 2, 1'b1, 16'd3, 32'd15);
      req_base = req_cnt;
      run_test(40, 0, 0, lat);
      check_eq("reg_pass", pass, 1);
      check_eq("reg_pass_cnt", pass_count, 3);
      check_eq("reg_fail_cnt", fail_count, 0);
      check_eq("reg_cycles", cycle_count, 40);
      check_eq("reg_ff_idx", first_fail_idx, 9'h1FF);
      check_eq("reg_no_mem_req", req_cnt - req_base, 0);

      // mismatch capture; start and cfg_we while busy must be ignored
      cfg_write(1'b0, 4, 1'b1, 16'd4, 32'd10);
      cfg_write(1'b0, 6, 1'b1, 16'd6, 32'd15);
      run_test(40, 10, 12, lat);
      check_eq("mm_fail_cnt", fail_count, 2);
      check_eq("mm_pass_cnt", pass_count, 3);
      check_eq("mm_ff_idx", first_fail_idx, 9'h004);
      check_eq("mm_ff_got", first_fail_got, 9);
      check_eq("mm_pass", pass, 0);
      check_eq("mm_cycles", cycle_count, 40);

      // watchdog: no halt
      run_test(0, 0, 0, lat);
      check_eq("wd_timeout", timeout, 1);
      check_eq("wd_cycles", cycle_count, 500);
      check_eq("wd_pass_cnt", pass_count, 3);
      check_eq("wd_fail_cnt", fail_count, 2);
      check_eq("wd_pass", pass, 0);

      // halt sampled when cycle_count==499
      run_test(500, 0, 0, lat);
      check_eq("hto_timeout", timeout, 0);
      check_eq("hto_cycles", cycle_count, 500);

      // reset while a memory request is outstanding
      do_reset();
      lat_cfg = 20;
      cfg_write(1'b0, 0, 1'b1, 16'd4, 32'd10);
      cfg_write(1'b1, 0, 1'b1, 16'd0, 32'd5);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0; halt = 1'b1;
      @(negedge clock);
      halt = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (dbg.mem_rd_req) break;
         @(negedge clock);
      end
      check_eq("mw_req_seen", dbg.mem_rd_req, 1);
      check_eq("mw_fail_before", fail_count, 1);
      do_reset();
      check_eq("mw_busy", busy, 0);
      check_eq("mw_done", done, 0);
      check_eq("mw_req", dbg.mem_rd_req, 0);
      check_eq("mw_fail_cnt", fail_count, 0);
      check_eq("mw_cycles", cycle_count, 0);
      check_eq("mw_ff_idx", first_fail_idx, 9'h1FF);
      req_base = req_cnt;
      run_test(3, 0, 0, lat);
      check_eq("mw_tbl_clear_lat", lat, 33);
      check_eq("mw_tbl_clear_pass", pass_count, 0);
      check_eq("mw_tbl_clear_fail", fail_count, 0);
      check_eq("mw_tbl_clear_req", req_cnt - req_base, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
